uart_tx_periph: RTL

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_periph_if.sv | 21 ++
 rtl/tx_fifo.sv | 59 +++++
 rtl/uart_tx_periph.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register addresses, FSM encoding and status bit positions for the UART transmitter
package uart_pkg;

    localparam logic [31:0] UART_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_CON = 32'h4000_001C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/uart_tx_periph_if.sv
// rtl/uart_tx_periph_if.sv - MEM-stage load/store bus between the CPU and the UART register block
interface uart_tx_periph_if;

    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Hit;

    modport master (
        output MemRd, MemWr, Addr, WrData,
        input  RdData, Hit
    );

    modport slave (
        input  MemRd, MemWr, Addr, WrData,
        output RdData, Hit
    );

endinterface

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - synchronous byte FIFO; a push into a full FIFO is taken when a pop lands on the same edge
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits, so the power-of-two depth gives free modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with a TX byte FIFO and sticky overflow flag
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_periph_if.slave    bus,
    output logic               Tx
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t      state;
    tx_state_t      state_n;
    logic [7:0]     shift;
    logic [7:0]     shift_n;
    logic [CW-1:0]  baud_cnt;
    logic [CW-1:0]  cnt_n;
    logic [2:0]     bit_idx;
    logic [2:0]     idx_n;
    logic           tx_n;
    logic           ovf;
    logic           bit_end;

    logic           sel_txd;
    logic           sel_con;
    logic           push;
    logic           pop;
    logic           clr_ovf;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [31:0]    status;
    logic           unused_ok;

    assign sel_txd   = (bus.Addr == UART_TXD);
    assign sel_con   = (bus.Addr == UART_CON);
    assign push      = bus.MemWr && sel_txd;
    assign clr_ovf   = bus.MemWr && sel_con;
    assign bit_end   = (baud_cnt == CNT_LAST);
    assign unused_ok = ^{bus.WrData[31:8], fifo_count};

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.WrData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = baud_cnt;
        idx_n   = bit_idx;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    cnt_n = baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        idx_n   = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level is decoded from the next state so the Tx flop changes on the same edge as the FSM.
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            Tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            baud_cnt <= cnt_n;
            bit_idx  <= idx_n;
            Tx       <= tx_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = (state != ST_IDLE);
        status[STAT_OVF]   = ovf;
    end

    assign bus.RdData = (bus.MemRd && sel_con) ? status : 32'h0;
    assign bus.Hit    = sel_txd || sel_con;

endmodule
